alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width (8..32).
REQ-002 Parameter FRW, default 16, flag register width (fixed bit map; at least 16).
REQ-003 Ports:
- wire_clock  in  1  single clock; all state on rising edge.
- wire_reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; accepted only when busy=0.
- opCode  in  6  operation select.
- m3, m4  in  WIDTH  operands A, B.
- useCarry  in  1  add/sub includes FR_in[11].
- dec  in  1  inc/dec select (1 = decrement).
- flagToShifthAndRot  in  3  shift/rotate mode.
- FR_in  in  FRW  incoming flags.
- m2  out  WIDTH  result.
- FR_out  out  FRW  updated flags.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.

Function
REQ-004 On an accepted start, the block SHALL register opCode, m3, m4, useCarry, dec, flagToShifthAndRot and FR_in[11]; later input changes SHALL not affect the operation.
REQ-005 The FSM SHALL use states IDLE -> EXEC -> DONE; div/mod SHALL go IDLE -> DIV -> DONE; DONE SHALL return to IDLE.
REQ-006 busy SHALL be 1 in EXEC, DIV and DONE; done SHALL be 1 only in DONE; m2/FR_out SHALL be valid when done=1 and held until the next completion.
REQ-007 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-008 Latency start->done SHALL be 2 cycles for all ops except div/mod, which SHALL be WIDTH+2 cycles (restoring divider, one quotient bit per cycle).
REQ-009 Opcodes:
- 100000 add: m2 = A+B(+c); FR[11] = carry out of WIDTH.
- 100001 sub: m2 = A-B(+c); if B > A(+c), FR[6]=1 and m2=0, else FR[6]=0.
- 100010 mul: m2 = low WIDTH bits of A*B; FR[10]=1 iff the high half is nonzero.
- 100011 div / 100101 mod: quotient / remainder; if B=0, FR[9]=1 and m2=0 with no DIV iterations (2-cycle latency), else FR[9]=0.
- 100100 inc/dec: m2 = A±1, modulo 2^WIDTH.
- 010010 and, 010011 or, 010100 xor, 010101 not(A).
- 010110 cmp: FR[15:13] = 100 if A>B, 010 if A<B, 001 if equal; m2 unchanged.
- 000110 restore: FR_out = FR_in; m2 unchanged.
- 010000 shift/rotate, with s = B mod 2^clog2(WIDTH): 00x shl, 01x shr (zero fill; B >= WIDTH gives 0); 10x rotate left by s; 11x rotate right by s.
REQ-010 All result-producing ops except shift/rotate SHALL set FR[12]=1 when m2=0, else clear it, including the inc and logic ops.
REQ-011 FR_out bits not named for an op SHALL keep their previous FR_out value.
REQ-012 An unlisted opCode SHALL complete in 2 cycles with m2 and FR_out unchanged.
REQ-013 All arithmetic SHALL be unsigned; carry/overflow SHALL be computed at WIDTH+1 / 2*WIDTH bits.

Reset
REQ-014 wire_reset_n=0 SHALL immediately force state IDLE, m2=0, FR_out=0, busy=0, done=0, and clear the divider registers.
REQ-015 Reset during EXEC/DIV SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Structure
REQ-016 Opcode constants, shift-mode codes, flag bit indices (EQ 13, LT 14, GT 15, ZERO 12, CARRY 11, OVF 10, DIVZ 9, NEG 6) and FSM state encodings SHALL live in a shared package alu_pkg.
REQ-017 The iterative divider SHALL be a sub-module alu_divider (WIDTH param; start/done; quotient, remainder).

Verification (WIDTH=16)
REQ-018 add: A=FFFF, B=0001, useCarry=0 -> done at cycle 2, m2=0000, FR[11]=1, FR[12]=1.
REQ-019 div: A=0064, B=0007 -> done at cycle 18, m2=000E; mod with the same operands -> m2=0002; div with B=0 -> cycle 2, m2=0, FR[9]=1.
REQ-020 rotr (110): A=0001, B=0001 -> m2=8000; rotl (100): A=8001, B=0004 -> m2=0018; shr: A=8000, B=0010 -> m2=0000.
REQ-021 sub: A=0003, B=0005 -> m2=0, FR[6]=1; cmp: A=0005, B=0003 -> FR[15:13]=100 and other FR bits held.
REQ-022 Start pulse during DIV (cycle 5) is ignored; wire_reset_n low at cycle 8 of a div -> outputs zero and no done; a new add after release completes in 2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, shift modes, flag bit map
// and FSM state encoding.
package alu_pkg;

  localparam logic [5:0] OP_ADD     = 6'b100000;
  localparam logic [5:0] OP_SUB     = 6'b100001;
  localparam logic [5:0] OP_MUL     = 6'b100010;
  localparam logic [5:0] OP_DIV     = 6'b100011;
  localparam logic [5:0] OP_INCDEC  = 6'b100100;
  localparam logic [5:0] OP_MOD     = 6'b100101;
  localparam logic [5:0] OP_AND     = 6'b010010;
  localparam logic [5:0] OP_OR      = 6'b010011;
  localparam logic [5:0] OP_XOR     = 6'b010100;
  localparam logic [5:0] OP_NOT     = 6'b010101;
  localparam logic [5:0] OP_CMP     = 6'b010110;
  localparam logic [5:0] OP_RESTORE = 6'b000110;
  localparam logic [5:0] OP_SHROT   = 6'b010000;

  // Upper two bits of the shift/rotate mode; the low bit is a don't-care.
  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ROL = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FR_GT    = 15;
  localparam int FR_LT    = 14;
  localparam int FR_EQ    = 13;
  localparam int FR_ZERO  = 12;
  localparam int FR_CARRY = 11;
  localparam int FR_OVF   = 10;
  localparam int FR_DIVZ  = 9;
  localparam int FR_NEG   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider: loads on start, retires one quotient bit per
// cycle and pulses done once all WIDTH bits are resolved.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             active_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (shifted >= {1'b0, dvs_q}) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= '0;
        quo_q    <= dividend;
        dvs_q    <= divisor;
        cnt_q    <= CNT_LOAD;
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          active_q <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: latches a request, evaluates it in one EXEC cycle (or via
// the iterative divider) and presents result/flags with a one-cycle done pulse.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRW   = 16
) (
  input  logic             wire_clock,
  input  logic             wire_reset_n,
  input  logic             start,
  input  logic [5:0]       opCode,
  input  logic [WIDTH-1:0] m3,
  input  logic [WIDTH-1:0] m4,
  input  logic             useCarry,
  input  logic             dec,
  input  logic [2:0]       flagToShifthAndRot,
  input  logic [FRW-1:0]   FR_in,
  output logic [WIDTH-1:0] m2,
  output logic [FRW-1:0]   FR_out,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [5:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             use_c_p0;
  logic             dec_p0;
  logic [2:0]       sh_p0;
  logic [FRW-1:0]   fr_in_p0;

  logic             div_go;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  logic [WIDTH-1:0]   ex_m2;
  logic [FRW-1:0]     ex_fr;
  logic               ex_zupd;
  logic [WIDTH:0]     cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     a_plus_c;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_m2;
  logic [FRW-1:0]     div_fr;

  function automatic logic [WIDTH-1:0] shift_rot(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       mode);
    logic [2*WIDTH-1:0] dbl;
    int                 r;
    dbl = {a, a};
    r   = int'(b[SW-1:0]) % WIDTH;
    casez (mode)
      {SH_SHL, 1'b?}: shift_rot = a << b;
      {SH_SHR, 1'b?}: shift_rot = a >> b;
      {SH_ROL, 1'b?}: begin
        dbl       = dbl << r;
        shift_rot = dbl[2*WIDTH-1:WIDTH];
      end
      default: begin
        dbl       = dbl >> r;
        shift_rot = dbl[WIDTH-1:0];
      end
    endcase
  endfunction

  // Divider is kicked straight from the accepting cycle so DIV spans WIDTH+1 cycles.
  assign div_go = (state == ST_IDLE) && start && is_div_op(opCode) && (m4 != '0);

  alu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (wire_clock),
    .rst_n    (wire_reset_n),
    .start    (div_go),
    .dividend (m3),
    .divisor  (m4),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // EXEC stage: single-cycle evaluation of latched operands
  always_comb begin
    ex_m2    = m2;
    ex_fr    = FR_out;
    ex_zupd  = 1'b0;
    cin      = {{WIDTH{1'b0}}, use_c_p0 & fr_in_p0[FR_CARRY]};
    sum      = {1'b0, a_p0} + {1'b0, b_p0} + cin;
    a_plus_c = {1'b0, a_p0} + cin;
    prod     = {{WIDTH{1'b0}}, a_p0} * {{WIDTH{1'b0}}, b_p0};
    case (op_p0)
      OP_ADD: begin
        ex_m2           = sum[WIDTH-1:0];
        ex_fr[FR_CARRY] = sum[WIDTH];
        ex_zupd         = 1'b1;
      end
      OP_SUB: begin
        if ({1'b0, b_p0} > a_plus_c) begin
          ex_m2         = '0;
          ex_fr[FR_NEG] = 1'b1;
        end else begin
          ex_m2         = a_plus_c[WIDTH-1:0] - b_p0;
          ex_fr[FR_NEG] = 1'b0;
        end
        ex_zupd = 1'b1;
      end
      OP_MUL: begin
        ex_m2         = prod[WIDTH-1:0];
        ex_fr[FR_OVF] = |prod[2*WIDTH-1:WIDTH];
        ex_zupd       = 1'b1;
      end
      // Only a zero divisor reaches EXEC for div/mod.
      OP_DIV, OP_MOD: begin
        ex_m2          = '0;
        ex_fr[FR_DIVZ] = 1'b1;
        ex_zupd        = 1'b1;
      end
      OP_INCDEC: begin
        ex_m2   = dec_p0 ? (a_p0 - ONE_W) : (a_p0 + ONE_W);
        ex_zupd = 1'b1;
      end
      OP_AND: begin ex_m2 = a_p0 & b_p0; ex_zupd = 1'b1; end
      OP_OR:  begin ex_m2 = a_p0 | b_p0; ex_zupd = 1'b1; end
      OP_XOR: begin ex_m2 = a_p0 ^ b_p0; ex_zupd = 1'b1; end
      OP_NOT: begin ex_m2 = ~a_p0;       ex_zupd = 1'b1; end
      OP_CMP: begin
        ex_fr[FR_GT] = a_p0 > b_p0;
        ex_fr[FR_LT] = a_p0 < b_p0;
        ex_fr[FR_EQ] = a_p0 == b_p0;
      end
      OP_RESTORE: ex_fr = fr_in_p0;
      OP_SHROT:   ex_m2 = shift_rot(a_p0, b_p0, sh_p0);
      default: ;
    endcase
    if (ex_zupd) ex_fr[FR_ZERO] = (ex_m2 == '0);
  end

  // DIV stage: result selection once the divider retires its last bit
  always_comb begin
    div_m2          = (op_p0 == OP_MOD) ? div_rem : div_quo;
    div_fr          = FR_out;
    div_fr[FR_DIVZ] = 1'b0;
    div_fr[FR_ZERO] = (div_m2 == '0);
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      state    <= ST_IDLE;
      m2       <= '0;
      FR_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_p0    <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      use_c_p0 <= 1'b0;
      dec_p0   <= 1'b0;
      sh_p0    <= '0;
      fr_in_p0 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_p0    <= opCode;
            a_p0     <= m3;
            b_p0     <= m4;
            use_c_p0 <= useCarry;
            dec_p0   <= dec;
            sh_p0    <= flagToShifthAndRot;
            fr_in_p0 <= FR_in;
            busy     <= 1'b1;
            state    <= div_go ? ST_DIV : ST_EXEC;
          end
        end
        ST_EXEC: begin
          m2     <= ex_m2;
          FR_out <= ex_fr;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DIV: begin
          if (div_done) begin
            m2     <= div_m2;
            FR_out <= div_fr;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
